phase_error_detector: RTL and testbench

- Edge-timing phase/frequency detector for the ADPLL.
- Measures the clk-cycle distance between rising edges of the reference clock and the divided DCO feedback clock.
- Emits an 8-bit magnitude plus a lead flag, the sign-magnitude format the loop filter's input consumes.
- Sits between the ref/feedback clock pins and the loop filter input; one result per reference period.

---
 rtl/phase_error_detector.sv | 130 +++++++++++++
 tb/tb_phase_error_detector.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/phase_error_detector.sv
// phase_error_detector: edge-timing phase/frequency detector producing sign-magnitude phase error per reference period
module phase_error_detector #(
  parameter int inout_width = 8,
  parameter int sync_stages = 2,
  parameter int timeout = 1023,
  parameter int cnt_width = 10
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   ref_in,
  input  logic                   fb_in,
  output logic [inout_width-1:0] phase_mag,
  output logic                   lead,
  output logic                   phase_valid,
  output logic                   slip
);
  typedef enum logic [1:0] {IDLE, REF_FIRST, FB_FIRST} state_t;
  localparam logic [cnt_width-1:0] mag_max = cnt_width'((1 << inout_width) - 1);
  localparam logic [cnt_width-1:0] cnt_limit = cnt_width'(timeout);
  localparam logic [cnt_width-1:0] one = cnt_width'(1);
  state_t state, state_n;
  logic [sync_stages-1:0] ref_sync, fb_sync;
  logic ref_d, fb_d, rise_ref, rise_fb;
  logic [cnt_width-1:0] cnt, cnt_n;
  logic first_ref, done, again;
  logic nv, nslip, nlead;
  logic [inout_width-1:0] nmag, sat_mag;
  logic res_v, res_slip, res_lead;
  logic [inout_width-1:0] res_mag;
  assign sat_mag = (cnt > mag_max) ? '1 : cnt[inout_width-1:0];
  assign first_ref = state == REF_FIRST;
  assign done = first_ref ? rise_fb : rise_ref;
  assign again = first_ref ? rise_ref : rise_fb;
  // synchronizers and rise detectors keep running even when disabled, so no false rise on re-enable
  always_ff @(posedge clk)
    if (rstn) begin
      ref_sync <= '0;
      fb_sync <= '0;
      ref_d <= 1'b0;
      fb_d <= 1'b0;
      rise_ref <= 1'b0;
      rise_fb <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[sync_stages-2:0], ref_in};
      fb_sync <= {fb_sync[sync_stages-2:0], fb_in};
      ref_d <= ref_sync[sync_stages-1];
      fb_d <= fb_sync[sync_stages-1];
      rise_ref <= ref_sync[sync_stages-1] & ~ref_d;
      rise_fb <= fb_sync[sync_stages-1] & ~fb_d;
    end
  // measurement FSM: completing edge beats slip, slip beats timeout
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    nv = 1'b0;
    nslip = 1'b0;
    nlead = res_lead;
    nmag = sat_mag;
    if (!en) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (state == IDLE) begin
      if (rise_ref && rise_fb) begin
        nv = 1'b1;
        nmag = '0;
      end else if (rise_ref || rise_fb) begin
        state_n = rise_ref ? REF_FIRST : FB_FIRST;
        cnt_n = one;
      end
    end else begin
      nlead = ~first_ref;
      if (done) begin
        nv = 1'b1;
        state_n = IDLE;
        cnt_n = '0;
      end else if (again) begin
        nv = 1'b1;
        nslip = 1'b1;
        nmag = '1;
        cnt_n = one;
      end else if (cnt == cnt_limit) begin
        nv = 1'b1;
        nslip = 1'b1;
        nmag = '1;
        state_n = IDLE;
        cnt_n = '0;
      end else cnt_n = cnt + one;
    end
  end
  // FSM state and interval counter
  always_ff @(posedge clk)
    if (rstn) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // result stage; res_lead also remembers the last lead for simultaneous edges
  always_ff @(posedge clk)
    if (rstn) begin
      res_v <= 1'b0;
      res_slip <= 1'b0;
      res_lead <= 1'b0;
      res_mag <= '0;
    end else begin
      res_v <= nv;
      res_slip <= nv & nslip;
      if (nv) begin
        res_mag <= nmag;
        res_lead <= nlead;
      end
    end
  // output registers: magnitude and lead hold between results, valid and slip pulse
  always_ff @(posedge clk)
    if (rstn) begin
      phase_valid <= 1'b0;
      slip <= 1'b0;
      phase_mag <= '0;
      lead <= 1'b0;
    end else begin
      phase_valid <= en & res_v;
      slip <= en & res_v & res_slip;
      if (en && res_v) begin
        phase_mag <= res_mag;
        lead <= res_lead;
      end
    end
endmodule

// File: tb/tb_phase_error_detector.sv
// tb_phase_error_detector: directed plus randomized edge stimulus checked against an edge-time model
module tb_phase_error_detector;
  localparam int n_hist = 70000;
  logic clk = 1'b0;
  logic rstn, en, ref_in, fb_in;
  logic [7:0] phase_mag;
  logic lead, phase_valid, slip;
  phase_error_detector dut (
    .clk(clk), .rstn(rstn), .en(en), .ref_in(ref_in), .fb_in(fb_in),
    .phase_mag(phase_mag), .lead(lead), .phase_valid(phase_valid), .slip(slip)
  );
  always #5 clk = ~clk;
  bit ref_h[n_hist];
  bit fb_h[n_hist];
  int cyc = 0, checks = 0, passes = 0;
  int ref_start = -100, fb_start = -100;
  bit en_lv = 1'b1, rst_lv = 1'b1, armed = 1'b0;
  int t0 = -1;
  bit first_ref, last_lead;
  bit m_rv, m_rslip, m_rlead;
  int m_rmag;
  bit e_valid, e_slip, e_lead;
  int e_mag;
  int nres;
  int r_cyc[8], r_mag[8];
  bit r_lead[8], r_slip[8];

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) passes++;
    else $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
  endtask

  task automatic post(input int mag, input bit ld, input bit s);
    m_rv = 1'b1;
    m_rmag = mag;
    m_rlead = ld;
    m_rslip = s;
    last_lead = ld;
  endtask

  // model: edges are seen three clocks after sampling, results appear one clock after that
  task automatic model_edge();
    int k, d;
    bit rr, rf, dn, ag;
    k = cyc;
    if (rst_lv) begin
      for (int i = k - 3; i <= k; i++) if (i >= 0) begin ref_h[i] = 1'b0; fb_h[i] = 1'b0; end
      t0 = -1; last_lead = 1'b0; m_rv = 1'b0; m_rlead = 1'b0; m_rslip = 1'b0; m_rmag = 0;
      e_valid = 1'b0; e_slip = 1'b0; e_lead = 1'b0; e_mag = 0;
      return;
    end
    e_valid = en_lv && m_rv;
    e_slip = e_valid && m_rslip;
    if (e_valid) begin e_mag = m_rmag; e_lead = m_rlead; end
    rr = k >= 4 && ref_h[k-3] && !ref_h[k-4];
    rf = k >= 4 && fb_h[k-3] && !fb_h[k-4];
    m_rv = 1'b0;
    if (!en_lv) t0 = -1;
    else if (t0 < 0) begin
      if (rr && rf) post(0, last_lead, 1'b0);
      else if (rr || rf) begin t0 = k; first_ref = rr; end
    end else begin
      d = k - t0;
      dn = first_ref ? rf : rr;
      ag = first_ref ? rr : rf;
      if (dn) begin post(d > 255 ? 255 : d, !first_ref, 1'b0); t0 = -1; end
      else if (ag) begin post(255, !first_ref, 1'b1); t0 = k; end
      else if (d == 1023) begin post(255, !first_ref, 1'b1); t0 = -1; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (armed) begin
      chk("phase_valid", phase_valid, e_valid);
      chk("slip", slip, e_slip);
      chk("phase_mag", phase_mag, e_mag);
      chk("lead", lead, e_lead);
      if (phase_valid === 1'b1 && nres < 8) begin
        r_cyc[nres] = cyc; r_mag[nres] = phase_mag; r_lead[nres] = lead; r_slip[nres] = slip;
        nres++;
      end
    end
    if (cyc >= n_hist - 2) begin
      $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, n_hist - 2);
      $fatal(1);
    end
    rstn = rst_lv;
    en = en_lv;
    ref_in = (cyc + 1 >= ref_start) && (cyc + 1 < ref_start + 6);
    fb_in = (cyc + 1 >= fb_start) && (cyc + 1 < fb_start + 6);
    @(posedge clk);
    cyc++;
    ref_h[cyc] = ref_in;
    fb_h[cyc] = fb_in;
    model_edge();
    if (rst_lv) armed = 1'b1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c - 1) tick();
  endtask

  task automatic expect_res(input int i, input int vc, input int mag, input bit ld, input bit s);
    chk($sformatf("res%0d_cycle", i), r_cyc[i], vc);
    chk($sformatf("res%0d_mag", i), r_mag[i], mag);
    chk($sformatf("res%0d_lead", i), r_lead[i], ld);
    chk($sformatf("res%0d_slip", i), r_slip[i], s);
  endtask

  initial begin
    int c, kind;
    rst_lv = 1'b1; ref_start = 1; fb_start = 3;
    wait_to(13);
    rst_lv = 1'b0;
    nres = 0; wait_to(100); ref_start = 100; wait_to(137); fb_start = 137; wait_to(160);
    chk("ref_lead_count", nres, 1); expect_res(0, 141, 37, 1'b0, 1'b0);
    nres = 0; wait_to(200); fb_start = 200; wait_to(205); ref_start = 205; wait_to(230);
    chk("fb_lead_count", nres, 1); expect_res(0, 209, 5, 1'b1, 1'b0);
    nres = 0; wait_to(250); ref_start = 250; fb_start = 250; wait_to(270);
    chk("simul_count", nres, 1); expect_res(0, 254, 0, 1'b1, 1'b0);
    nres = 0; wait_to(300); ref_start = 300; wait_to(600); fb_start = 600; wait_to(620);
    chk("sat_count", nres, 1); expect_res(0, 604, 255, 1'b0, 1'b0);
    nres = 0; wait_to(700); ref_start = 700; wait_to(1760);
    chk("timeout_count", nres, 1); expect_res(0, 1727, 255, 1'b0, 1'b1);
    nres = 0; wait_to(2000); ref_start = 2000; wait_to(2400); ref_start = 2400;
    wait_to(2450); fb_start = 2450; wait_to(2480);
    chk("slip_count", nres, 2); expect_res(0, 2404, 255, 1'b0, 1'b1); expect_res(1, 2454, 50, 1'b0, 1'b0);
    nres = 0; wait_to(2600); ref_start = 2600; wait_to(2610); en_lv = 1'b0; wait_to(2616); en_lv = 1'b1;
    wait_to(2700); fb_start = 2700; wait_to(2720); ref_start = 2720; wait_to(2760);
    chk("en_drop_count", nres, 1); expect_res(0, 2724, 20, 1'b1, 1'b0);
    nres = 0; wait_to(2800); ref_start = 2800; wait_to(2810); rst_lv = 1'b1; wait_to(2813); rst_lv = 1'b0;
    wait_to(2900); fb_start = 2900; wait_to(2920); ref_start = 2920; wait_to(2960);
    chk("mid_reset_count", nres, 1); expect_res(0, 2924, 20, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      kind = $urandom_range(0, 9);
      c = cyc + 1 + $urandom_range(1, 1100);
      if (kind == 9) begin
        wait_to(c); en_lv = 1'b0;
        wait_to(cyc + 1 + $urandom_range(1, 8)); en_lv = 1'b1;
      end else begin
        if (kind != 4 && kind != 5 && kind != 6 && kind != 7 && c < ref_start + 7) c = ref_start + 7;
        if (kind >= 4 && c < fb_start + 7) c = fb_start + 7;
        wait_to(c);
        if (kind < 4 || kind == 8) ref_start = c;
        if (kind >= 4) fb_start = c;
      end
    end
    wait_to(cyc + 1100);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
